call_stack_param: RTL and testbench

- Parametrised return-address stack for the CPU control path.
- Stores {PC, flags} pairs: pushed on CALL/interrupt entry, popped on RET/RETI.
- Successor of the fixed 5-deep, 9-bit-PC stack. Adds:
  - configurable width and depth;
  - a selectable full-stack policy;
  - explicit full/empty/count status;
  - sticky overflow/underflow error flags;
  - defined simultaneous push+pop semantics.

---
 rtl/call_stack_param_if.sv | 32 +++
 rtl/call_stack_param.sv | 98 +++++++++
 tb/tb_call_stack_param.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/call_stack_param_if.sv
// Bus bundle for call_stack_param: push/pop controls, push data, and top-of-stack/status outputs.
// The stack itself is the slave; the control path driving it is the master.
interface call_stack_param_if #(
    parameter int PC_W    = 9,
    parameter int FLAGS_W = 4,
    parameter int DEPTH   = 5
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               push_en;
    logic               pop_en;
    logic               err_clr;
    logic [PC_W-1:0]    in_pc;
    logic [FLAGS_W-1:0] in_flags;
    logic [PC_W-1:0]    out_pc;
    logic [FLAGS_W-1:0] out_flags;
    logic [CW-1:0]      count;
    logic               empty;
    logic               full;
    logic               overflow;
    logic               underflow;

    modport master (
        output push_en, pop_en, err_clr, in_pc, in_flags,
        input  out_pc, out_flags, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push_en, pop_en, err_clr, in_pc, in_flags,
        output out_pc, out_flags, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack_param.sv
// Parametrised return-address stack of {PC, flags} pairs with full-policy select,
// count/full/empty status and sticky overflow/underflow flags.
module call_stack_param #(
    parameter int PC_W      = 9,
    parameter int FLAGS_W   = 4,
    parameter int DEPTH     = 5,
    parameter int WRAP_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    call_stack_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = PC_W + FLAGS_W;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] top_ptr;
    logic [PW-1:0] top_inc;
    logic [PW-1:0] top_dec;
    logic [PW-1:0] top_nxt;
    logic [PW-1:0] wr_addr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ovf;
    logic          unf;
    logic          ovf_evt;
    logic          unf_evt;
    logic          wr_en;
    logic          is_empty;
    logic          is_full;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign top_inc  = (top_ptr == PW'(DEPTH - 1)) ? '0 : top_ptr + 1'b1;
    assign top_dec  = (top_ptr == '0) ? PW'(DEPTH - 1) : top_ptr - 1'b1;

    // Push+pop on an empty stack falls through to the plain-push branch.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = top_inc;
        top_nxt = top_ptr;
        cnt_nxt = cnt;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (bus.push_en && bus.pop_en && !is_empty) begin
            wr_en   = 1'b1;
            wr_addr = top_ptr;
        end else if (bus.push_en) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                top_nxt = top_inc;
                cnt_nxt = cnt + 1'b1;
            end else begin
                ovf_evt = 1'b1;
                if (WRAP_MODE != 0) begin
                    wr_en   = 1'b1;
                    top_nxt = top_inc;
                end
            end
        end else if (bus.pop_en) begin
            if (!is_empty) begin
                top_nxt = top_dec;
                cnt_nxt = cnt - 1'b1;
            end else begin
                unf_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            top_ptr <= top_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf_evt | (ovf & ~bus.err_clr);
            unf     <= unf_evt | (unf & ~bus.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= {bus.in_pc, bus.in_flags};
        end
    end

    assign bus.out_pc    = is_empty ? '0 : mem[top_ptr][EW-1:FLAGS_W];
    assign bus.out_flags = is_empty ? '0 : mem[top_ptr][FLAGS_W-1:0];
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;
endmodule

// File: tb/tb_call_stack_param.sv
// Bench for call_stack_param: drop-on-full and wrap-on-full instances driven in lockstep,
// both compared every cycle against a shifting-array stack model.
module tb_call_stack_param;
    localparam int PC_W    = 9;
    localparam int FLAGS_W = 4;
    localparam int DEPTH   = 5;
    localparam int EW      = PC_W + FLAGS_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    call_stack_param_if #(.PC_W(PC_W), .FLAGS_W(FLAGS_W), .DEPTH(DEPTH)) bus0 ();
    call_stack_param_if #(.PC_W(PC_W), .FLAGS_W(FLAGS_W), .DEPTH(DEPTH)) bus1 ();

    call_stack_param #(.PC_W(PC_W), .FLAGS_W(FLAGS_W), .DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    call_stack_param #(.PC_W(PC_W), .FLAGS_W(FLAGS_W), .DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: index 0 is the oldest entry, msz-1 the top; index s=1 is the wrapping stack.
    logic [EW-1:0] mq [2][DEPTH];
    int            msz [2];
    logic          mov [2];
    logic          mun [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] m_top(input int s);
        return (msz[s] > 0) ? mq[s][msz[s]-1] : '0;
    endfunction

    task automatic model_step(input logic p, input logic po, input logic c, input logic r,
                              input logic [EW-1:0] d);
        for (int s = 0; s < 2; s++) begin
            logic eo;
            logic eu;
            eo = 1'b0;
            eu = 1'b0;
            if (r) begin
                msz[s] = 0;
                mov[s] = 1'b0;
                mun[s] = 1'b0;
            end else begin
                if (p && po && msz[s] > 0) begin
                    mq[s][msz[s]-1] = d;
                end else if (p) begin
                    if (msz[s] < DEPTH) begin
                        mq[s][msz[s]] = d;
                        msz[s]++;
                    end else begin
                        eo = 1'b1;
                        if (s == 1) begin
                            for (int k = 0; k < DEPTH - 1; k++) mq[s][k] = mq[s][k+1];
                            mq[s][DEPTH-1] = d;
                        end
                    end
                end else if (po) begin
                    if (msz[s] > 0) msz[s]--;
                    else eu = 1'b1;
                end
                if (c) begin
                    mov[s] = 1'b0;
                    mun[s] = 1'b0;
                end
                if (eo) mov[s] = 1'b1;
                if (eu) mun[s] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [EW-1:0] t0;
        logic [EW-1:0] t1;
        t0 = m_top(0);
        t1 = m_top(1);
        chk("d0_count", 32'(bus0.count), 32'(msz[0]));
        chk("d0_empty", 32'(bus0.empty), 32'(msz[0] == 0));
        chk("d0_full", 32'(bus0.full), 32'(msz[0] == DEPTH));
        chk("d0_out_pc", 32'(bus0.out_pc), 32'(t0[EW-1:FLAGS_W]));
        chk("d0_out_flags", 32'(bus0.out_flags), 32'(t0[FLAGS_W-1:0]));
        chk("d0_overflow", 32'(bus0.overflow), 32'(mov[0]));
        chk("d0_underflow", 32'(bus0.underflow), 32'(mun[0]));
        chk("d1_count", 32'(bus1.count), 32'(msz[1]));
        chk("d1_empty", 32'(bus1.empty), 32'(msz[1] == 0));
        chk("d1_full", 32'(bus1.full), 32'(msz[1] == DEPTH));
        chk("d1_out_pc", 32'(bus1.out_pc), 32'(t1[EW-1:FLAGS_W]));
        chk("d1_out_flags", 32'(bus1.out_flags), 32'(t1[FLAGS_W-1:0]));
        chk("d1_overflow", 32'(bus1.overflow), 32'(mov[1]));
        chk("d1_underflow", 32'(bus1.underflow), 32'(mun[1]));
    endtask

    // Drive one cycle on both stacks, step the model at the edge, check 1 time unit later.
    task automatic cyc(input logic p, input logic po, input logic c, input logic r,
                       input logic [PC_W-1:0] pc, input logic [FLAGS_W-1:0] fl);
        rst           = r;
        bus0.push_en  = p;  bus1.push_en  = p;
        bus0.pop_en   = po; bus1.pop_en   = po;
        bus0.err_clr  = c;  bus1.err_clr  = c;
        bus0.in_pc    = pc; bus1.in_pc    = pc;
        bus0.in_flags = fl; bus1.in_flags = fl;
        @(posedge clk);
        model_step(p, po, c, r, {pc, fl});
        #1;
        check_all();
    endtask

    initial begin
        msz[0] = 0; msz[1] = 0;
        mov[0] = 1'b0; mov[1] = 1'b0;
        mun[0] = 1'b0; mun[1] = 1'b0;

        cyc(0, 0, 0, 1, '0, '0);
        cyc(0, 0, 0, 1, '0, '0);
        cyc(0, 0, 0, 0, '0, '0);
        chk("reset_empty", 32'(bus0.empty), 32'd1);
        chk("reset_out_pc", 32'(bus1.out_pc), 32'd0);

        // Fill then drain
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 9'(9'h010 + i), 4'(i + 1));
        chk("fill_full", 32'(bus0.full), 32'd1);
        chk("fill_top", 32'(bus0.out_pc), 32'h014);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, '0, '0);
        chk("drain_empty_pc", 32'(bus0.out_pc), 32'd0);

        // Push while full: drop vs wrap
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 9'(9'h010 + i), 4'(i + 1));
        cyc(1, 0, 0, 0, 9'h1FF, 4'h9);
        chk("drop_top", 32'(bus0.out_pc), 32'h014);
        chk("wrap_top", 32'(bus1.out_pc), 32'h1FF);
        chk("wrap_count", 32'(bus1.count), 32'd5);
        cyc(0, 1, 0, 0, '0, '0);
        chk("wrap_pop1", 32'(bus1.out_pc), 32'h014);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, '0, '0);
        chk("wrap_lost_oldest", 32'(bus1.empty), 32'd1);

        // Push+pop replace, and push+pop on empty
        cyc(1, 0, 1, 0, 9'h020, 4'h2);
        cyc(1, 1, 0, 0, 9'h0AB, 4'hF);
        chk("replace_pc", 32'(bus0.out_pc), 32'h0AB);
        chk("replace_count", 32'(bus0.count), 32'd1);
        cyc(0, 1, 0, 0, '0, '0);
        cyc(1, 1, 0, 0, 9'h055, 4'h3);
        chk("pp_empty_pc", 32'(bus0.out_pc), 32'h055);
        chk("pp_empty_unf", 32'(bus0.underflow), 32'd0);
        cyc(0, 1, 0, 0, '0, '0);

        // Underflow, set-wins-over-clear, then clear
        cyc(0, 1, 0, 0, '0, '0);
        chk("unf_set", 32'(bus0.underflow), 32'd1);
        cyc(0, 1, 1, 0, '0, '0);
        chk("unf_set_wins", 32'(bus0.underflow), 32'd1);
        cyc(0, 0, 1, 0, '0, '0);
        chk("unf_cleared", 32'(bus0.underflow), 32'd0);

        // Push-and-pop replace while full must not raise overflow
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 9'(9'h030 + i), 4'(i));
        cyc(1, 1, 0, 0, 9'h077, 4'h7);
        chk("full_pp_no_ovf", 32'(bus1.overflow), 32'd0);

        // Reset overrides a pending push
        cyc(0, 0, 0, 1, '0, '0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 9'(9'h040 + i), 4'(i));
        cyc(1, 0, 0, 1, 9'h0EE, 4'hE);
        chk("rst_mid_count", 32'(bus0.count), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic r, p, po, c;
            r  = ($urandom_range(0, 59) == 0);
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            c  = ($urandom_range(0, 7) == 0);
            cyc(p, po, c, r, 9'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
